// File: rtl/pwm_duty_capture_pkg.sv
// Shared constants, FSM encoding and helpers for PWM input capture.
// Widths here must match the pwm_duty_capture_if signals.
package pwm_duty_capture_pkg;

  localparam int unsigned CntW           = 16;
  localparam int unsigned DutyW          = 8;
  localparam int unsigned TimeoutDefault = 1023;

  localparam logic [DutyW-1:0] DutyMax = {DutyW{1'b1}};

  typedef enum logic [1:0] {
    StSync,
    StHigh,
    StLow,
    StStatic
  } cap_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == {CntW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [DutyW-1:0] sat_duty(input logic [CntW-1:0] v);
    if (v > {{(CntW-DutyW){1'b0}}, DutyMax}) begin
      return DutyMax;
    end
    return v[DutyW-1:0];
  endfunction

endpackage

// File: rtl/pwm_duty_capture_if.sv
// PWM capture bus: raw PWM line in, measurement results out.
// The slave modport is the capture block, the master modport is its user.
interface pwm_duty_capture_if;
  import pwm_duty_capture_pkg::*;

  logic             pwm_in;
  logic [CntW-1:0]  high_time;
  logic [CntW-1:0]  period;
  logic [DutyW-1:0] duty;
  logic             valid;
  logic             static_lvl;

  modport master (
    output pwm_in,
    input  high_time,
    input  period,
    input  duty,
    input  valid,
    input  static_lvl
  );

  modport slave (
    input  pwm_in,
    output high_time,
    output period,
    output duty,
    output valid,
    output static_lvl
  );

endinterface

// File: rtl/pwm_duty_capture_edge_sync.sv
// Two-flop synchronizer with rise/fall pulse outputs for asynchronous inputs.
// Define PWM_CAP_GLITCH_FILTER_EN to add a 3-sample majority filter (rejects 1-clk glitches).
module pwm_duty_capture_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       level_q;
  logic       s_in;

`ifdef PWM_CAP_GLITCH_FILTER_EN
  // hist_q[0] is the previous synchronized sample, hist_q[1] the one before.
  logic [1:0] hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end

  always_comb begin
    s_in = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end
`else
  always_comb begin
    s_in = sync_q[1];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], d_i};
      level_q <= s_in;
    end
  end

  always_comb begin
    level_o = s_in;
    rise_o  = s_in & ~level_q;
    fall_o  = ~s_in & level_q;
  end

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures high time, period and 8-bit duty code of one PWM line; flags a static line.
// Optional majority glitch filter in the input stage: PWM_CAP_GLITCH_FILTER_EN.
module pwm_duty_capture
  import pwm_duty_capture_pkg::*;
#(
  parameter int unsigned Timeout = TimeoutDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pwm_duty_capture_if.slave    cap_io
);

  localparam logic [CntW-1:0] TimeoutVal  = CntW'(Timeout);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(Timeout - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  logic level, rise, fall, edge_any;

  pwm_duty_capture_edge_sync u_edge_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (cap_io.pwm_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  cap_state_e       state_q;
  logic [CntW-1:0]  cnt_h_q, cnt_p_q, to_cnt_q;
  logic [CntW-1:0]  high_time_q, period_q;
  logic [DutyW-1:0] duty_q;
  logic             valid_q, static_q;
  logic             timeout_hit;

  always_comb begin
    edge_any    = rise | fall;
    timeout_hit = (state_q != StStatic) && !edge_any && (to_cnt_q == TimeoutLast);
  end

  // Counters include the edge cycle itself, so a restart loads 1, not 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StSync;
      cnt_h_q     <= '0;
      cnt_p_q     <= '0;
      to_cnt_q    <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      static_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if (edge_any) begin
        to_cnt_q <= '0;
      end else if (state_q != StStatic) begin
        to_cnt_q <= sat_inc(to_cnt_q);
      end

      if (timeout_hit) begin
        state_q     <= StStatic;
        static_q    <= 1'b1;
        duty_q      <= level ? DutyMax : '0;
        high_time_q <= level ? TimeoutVal : '0;
        period_q    <= TimeoutVal;
        valid_q     <= 1'b1;
      end else begin
        unique case (state_q)
          StSync: begin
            if (rise) begin
              cnt_h_q <= CntOne;
              cnt_p_q <= CntOne;
              state_q <= StHigh;
            end
          end
          StHigh: begin
            cnt_p_q <= sat_inc(cnt_p_q);
            if (fall) begin
              state_q <= StLow;
            end else begin
              cnt_h_q <= sat_inc(cnt_h_q);
            end
          end
          StLow: begin
            if (rise) begin
              high_time_q <= cnt_h_q;
              period_q    <= cnt_p_q;
              duty_q      <= sat_duty(cnt_h_q);
              static_q    <= 1'b0;
              valid_q     <= 1'b1;
              cnt_h_q     <= CntOne;
              cnt_p_q     <= CntOne;
              state_q     <= StHigh;
            end else begin
              cnt_p_q <= sat_inc(cnt_p_q);
            end
          end
          StStatic: begin
            // A falling edge leaves a partial period, so resync on the next rise.
            if (rise) begin
              cnt_h_q <= CntOne;
              cnt_p_q <= CntOne;
              state_q <= StHigh;
            end else if (fall) begin
              state_q <= StSync;
            end
          end
          default: state_q <= StSync;
        endcase
      end
    end
  end

  assign cap_io.high_time  = high_time_q;
  assign cap_io.period     = period_q;
  assign cap_io.duty       = duty_q;
  assign cap_io.valid      = valid_q;
  assign cap_io.static_lvl = static_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture: loop-back trains, static lines, saturation,
// glitches and mid-phase reset, with hand-computed expectations.
module tb_pwm_duty_capture;
  import pwm_duty_capture_pkg::*;

  localparam int unsigned Timeout = 1023;
`ifdef PWM_CAP_GLITCH_FILTER_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;

  pwm_duty_capture_if cap_if ();

  pwm_duty_capture #(.Timeout(Timeout)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cap_io (cap_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int vcnt   = 0;
  int v_cyc  = 0;
  int chg_cyc = 0;
  int q_h[$];
  int q_p[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_if.valid === 1'b1) begin
      vcnt  = vcnt + 1;
      v_cyc = cyc;
      q_h.push_back(int'(cap_if.high_time));
      q_p.push_back(int'(cap_if.period));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Hold the PWM line at lvl for n sampling clocks; inputs change 1 time unit after posedge.
  task automatic drive(input logic lvl, input int n);
    if (cap_if.pwm_in !== lvl) chg_cyc = cyc;
    cap_if.pwm_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_outputs(input string tag, input int h, input int p, input int d,
                               input int s);
    check({tag, ".high_time"},  32'(cap_if.high_time),  h);
    check({tag, ".period"},     32'(cap_if.period),     p);
    check({tag, ".duty"},       32'(cap_if.duty),       d);
    check({tag, ".static_lvl"}, 32'(cap_if.static_lvl), s);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, rc, fc, n;
    cap_if.pwm_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 0, 0, 0, 0);
    check("reset.valid", 32'(cap_if.valid), 0);
    rst_n = 1'b1;
    drive(0, 5);

    // 1: 64/256 train; first period only arms the FSM.
    v0 = vcnt;
    drive(1, 64); drive(0, 192);
    check("t1.no_first_publish", vcnt - v0, 0);
    drive(1, 64); drive(0, 192);
    drive(1, 64); rc = chg_cyc; drive(0, 192);
    check("t1.valid_count", vcnt - v0, 2);
    check("t1.rise_latency", v_cyc - rc, Lat);
    check_outputs("t1", 64, 256, 64, 0);

    // 2: line held low -> static low.
    fc = chg_cyc;
    v0 = vcnt;
    drive(0, 1100);
    check("t2.valid_count", vcnt - v0, 1);
    check("t2.timeout_latency", v_cyc - fc, Timeout + Lat);
    check_outputs("t2", 0, 1023, 0, 1);

    // 3: line held high -> static high, then recovery on a 100/156 train.
    v0 = vcnt;
    drive(1, 1100);
    check("t3.static_valid_count", vcnt - v0, 1);
    check_outputs("t3.static", 1023, 1023, 255, 1);
    v0 = vcnt;
    drive(1, 100); drive(0, 156); drive(1, 100); drive(0, 156); drive(1, 10);
    check("t3.recover_valid_count", vcnt - v0, 1);
    check_outputs("t3.recover", 100, 256, 100, 0);

    // 4: 300/500 external PWM, duty saturates.
    v0 = vcnt;
    drive(1, 290); drive(0, 200); drive(1, 300); drive(0, 200); drive(1, 10);
    check("t4.valid_count", vcnt - v0, 2);
    check_outputs("t4", 300, 500, 255, 0);

    // 5: 1-clk low glitch inside the high phase.
    v0 = vcnt;
    drive(1, 54); drive(0, 192);
    drive(1, 30); drive(0, 1); drive(1, 33); drive(0, 192); drive(1, 10);
    n = q_h.size();
`ifdef PWM_CAP_GLITCH_FILTER_EN
    check("t5.valid_count", vcnt - v0, 2);
    check("t5.prev_high", q_h[n-2], 64);
    check("t5.prev_period", q_p[n-2], 256);
    check_outputs("t5", 64, 256, 64, 0);
`else
    check("t5.valid_count", vcnt - v0, 3);
    check("t5.glitch_high", q_h[n-2], 30);
    check("t5.glitch_period", q_p[n-2], 31);
    check_outputs("t5", 33, 225, 33, 0);
`endif

    // Outputs hold between publishes.
    drive(1, 20);
    check("hold.high_time", 32'(cap_if.high_time), q_h[q_h.size()-1]);

    // 6: reset mid-high clears outputs at once; two full rises needed afterwards.
    rst_n = 1'b0;
    #1;
    check_outputs("t6.reset", 0, 0, 0, 0);
    check("t6.reset.valid", 32'(cap_if.valid), 0);
    #0;
    @(posedge clk); #1;
    drive(1, 23); drive(0, 100);
    rst_n = 1'b1;
    drive(0, 92);
    v0 = vcnt;
    drive(1, 64); drive(0, 192);
    check("t6.no_first_publish", vcnt - v0, 0);
    drive(1, 64); drive(0, 192);
    check("t6.valid_count", vcnt - v0, 1);
    check_outputs("t6", 64, 256, 64, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
